// File: rtl/aes_key_expand_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_expand_ctrl
//
// Word-serial AES-128 key-expansion sequencer. It produces round keys 0..10
// in FIPS-197 order at one expanded word per clock. A single external 32-bit
// SubWord unit is shared through sub_in/sub_out.
//
// Ports
//   clk       in   1    clock, all state updates on the rising edge
//   rst       in   1    synchronous, active-high reset
//   start     in   1    begin expansion (only looked at while idle)
//   key_in    in   128  cipher key, w0 = key_in[127:96] .. w3 = key_in[31:0]
//   busy      out  1    expansion in progress (EXPAND and DONE)
//   done      out  1    one-cycle pulse, coincident with the round-10 rk_valid
//   rk_valid  out  1    one-cycle pulse, rk_out/rk_round are valid
//   rk_round  out  4    round index of rk_out
//   rk_out    out  128  last completed round key {w0,w1,w2,w3}
//   sub_in    out  32   RotWord(w3) sent to the S-box (combinational)
//   sub_out   in   32   SubWord(sub_in) returned by the S-box (combinational)
// ---------------------------------------------------------------------------
module aes_key_expand_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_out,
  output logic [31:0]  sub_in,
  input  logic [31:0]  sub_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] win_q, win_d;        // {w0,w1,w2,w3}
  logic [1:0]   j_q, j_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         rk_valid_q, rk_valid_d;
  logic [3:0]   rk_round_q, rk_round_d;
  logic [127:0] rk_out_q, rk_out_d;

  logic [31:0]  w0, w3;
  logic [31:0]  temp_word;
  logic [31:0]  new_word;
  logic [127:0] win_shift;
  logic [7:0]   rcon_next;

  assign w0 = win_q[127:96];
  assign w3 = win_q[31:0];

  // RotWord(w3) goes to the S-box every cycle; its result is only used
  // when j == 0, i.e. on the first word of each round.
  assign sub_in    = {w3[23:0], w3[31:24]};
  assign temp_word = (j_q == 2'd0) ? (sub_out ^ {rcon_q, 24'h000000}) : w3;
  assign new_word  = w0 ^ temp_word;
  assign win_shift = {win_q[95:0], new_word};

  // Multiplication by x in GF(2^8).
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    j_d        = j_q;
    rnd_d      = rnd_q;
    rcon_d     = rcon_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rk_valid_d = 1'b0;
    rk_round_d = rk_round_q;
    rk_out_d   = rk_out_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          win_d      = key_in;
          j_d        = 2'd0;
          rnd_d      = 4'd0;
          rcon_d     = 8'h01;
          rk_valid_d = 1'b1;
          rk_round_d = 4'd0;
          rk_out_d   = key_in;
          busy_d     = 1'b1;
          state_d    = EXPAND;
        end
      end

      EXPAND: begin
        win_d = win_shift;
        j_d   = j_q + 2'd1;
        // Fourth word of a round: the shifted window is a full round key.
        if (j_q == 2'd3) begin
          rnd_d      = rnd_q + 4'd1;
          rk_valid_d = 1'b1;
          rk_round_d = rnd_q + 4'd1;
          rk_out_d   = win_shift;
          rcon_d     = rcon_next;
          if (rnd_q == 4'd9) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= '0;
      j_q        <= 2'd0;
      rnd_q      <= 4'd0;
      rcon_q     <= 8'h01;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_round_q <= 4'd0;
      rk_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      j_q        <= j_d;
      rnd_q      <= rnd_d;
      rcon_q     <= rcon_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rk_valid_q <= rk_valid_d;
      rk_round_q <= rk_round_d;
      rk_out_q   <= rk_out_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rk_valid = rk_valid_q;
  assign rk_round = rk_round_q;
  assign rk_out   = rk_out_q;

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expand_ctrl
//
// Self-checking bench for aes_key_expand_ctrl. The S-box is modelled here
// from its algebraic definition (GF(2^8) inverse plus affine map), and the
// expected round keys come from a textbook FIPS-197 key schedule built into
// a 44-word array. Every cycle of a run is compared against that schedule.
// ---------------------------------------------------------------------------
module tb_aes_key_expand_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic [127:0] rk_out;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mw [44];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  always #5 clk = ~clk;

  aes_key_expand_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .done     (done),
    .rk_valid (rk_valid),
    .rk_round (rk_round),
    .rk_out   (rk_out),
    .sub_in   (sub_in),
    .sub_out  (sub_out)
  );

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);   // a^254 = a^-1, 0 -> 0
    return (a == 8'h00) ? 8'h00 : r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rotword(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  assign sub_out = subword(sub_in);

  task automatic build_model(input logic [127:0] key);
    logic [7:0] rc = 8'h01;
    mw[0] = key[127:96];
    mw[1] = key[95:64];
    mw[2] = key[63:32];
    mw[3] = key[31:0];
    for (int i = 4; i < 44; i++) begin
      if (i % 4 == 0) begin
        mw[i] = mw[i-4] ^ subword(rotword(mw[i-1])) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else begin
        mw[i] = mw[i-4] ^ mw[i-1];
      end
    end
  endtask

  function automatic logic [127:0] model_rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks += 6;
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
    if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got %b expected 0", done); end
    if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rk_valid got %b expected 0", rk_valid); end
    if (rk_round !== 4'd0) begin n_fail++; $display("FAIL reset_rk_round got %0d expected 0", rk_round); end
    if (rk_out !== '0)     begin n_fail++; $display("FAIL reset_rk_out got %h expected 0", rk_out); end
    if (sub_in !== 32'h0)  begin n_fail++; $display("FAIL reset_sub_in got %h expected 0", sub_in); end
    $display("test_reset: done");
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One complete expansion, checked every cycle from cycle 1 to cycle 42.
  // Must be entered right after a falling edge; start is sampled on the
  // following rising edge (edge 0). On return the bench sits just after the
  // falling edge of cycle 42 with start = hold.
  task automatic test_expansion(input logic [127:0] key, input bit hold,
                                input bit inject, input bit fixed,
                                input logic [127:0] r1, input logic [127:0] r10,
                                input string name);
    int pulses = 0;
    int last_r;
    int widx;
    bit exp_v;
    logic [127:0] exp_rk;
    build_model(key);
    start  = 1'b1;
    key_in = key;
    @(posedge clk);
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      exp_v  = (c <= 41) && ((c - 1) % 4 == 0);
      last_r = (c > 41) ? 10 : (c - 1) / 4;
      exp_rk = model_rk(last_r);
      widx   = ((c > 41) ? 41 : c) + 2;
      n_checks += 5;
      if (rk_valid !== exp_v)
        begin n_fail++; $display("FAIL %s rk_valid cycle %0d got %b expected %b", name, c, rk_valid, exp_v); end
      if (done !== (c == 41))
        begin n_fail++; $display("FAIL %s done cycle %0d got %b expected %b", name, c, done, c == 41); end
      if (busy !== (c <= 41))
        begin n_fail++; $display("FAIL %s busy cycle %0d got %b expected %b", name, c, busy, c <= 41); end
      if (rk_out !== exp_rk)
        begin n_fail++; $display("FAIL %s rk_out cycle %0d got %h expected %h", name, c, rk_out, exp_rk); end
      if (sub_in !== rotword(mw[widx]))
        begin n_fail++; $display("FAIL %s sub_in cycle %0d got %h expected %h", name, c, sub_in, rotword(mw[widx])); end
      if (exp_v) begin
        n_checks++;
        if (rk_round !== 4'(last_r))
          begin n_fail++; $display("FAIL %s rk_round cycle %0d got %0d expected %0d", name, c, rk_round, last_r); end
        $display("%s: round %0d cycle %0d rk_out=%h", name, last_r, c, rk_out);
      end
      if (rk_valid === 1'b1) pulses++;
      if (fixed && (c == 5 || c == 41)) begin
        n_checks++;
        if (rk_out !== ((c == 5) ? r1 : r10))
          begin n_fail++; $display("FAIL %s known_vector cycle %0d got %h expected %h", name, c, rk_out, (c == 5) ? r1 : r10); end
      end
      start  = hold ? 1'b1 : (inject && (c == 10 || c == 41));
      key_in = inject ? {$urandom, $urandom, $urandom, $urandom} : key;
    end
    n_checks++;
    if (pulses != 11)
      begin n_fail++; $display("FAIL %s pulse_count got %0d expected 11", name, pulses); end
  endtask

  task automatic test_fips();
    test_expansion(FIPS_KEY, 1'b0, 1'b0, 1'b1, FIPS_R1, FIPS_R10, "fips");
  endtask

  task automatic test_zero_key();
    test_expansion(128'h0, 1'b0, 1'b0, 1'b1, ZERO_R1, ZERO_R10, "zero_key");
  endtask

  task automatic test_back_to_back();
    // start stays high: first run ignores it until idle, second run starts
    // straight away at edge 42 and must repeat the same keys.
    test_expansion(FIPS_KEY, 1'b1, 1'b0, 1'b1, FIPS_R1, FIPS_R10, "held_run1");
    test_expansion(FIPS_KEY, 1'b0, 1'b0, 1'b1, FIPS_R1, FIPS_R10, "held_run2");
  endtask

  task automatic test_ignored_start();
    test_expansion(FIPS_KEY, 1'b0, 1'b1, 1'b1, FIPS_R1, FIPS_R10, "ignored_start");
    start = 1'b0;
  endtask

  task automatic test_rst_mid();
    build_model(FIPS_KEY);
    start  = 1'b1;
    key_in = FIPS_KEY;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (rk_valid !== ((c - 1) % 4 == 0))
        begin n_fail++; $display("FAIL rst_mid rk_valid cycle %0d got %b", c, rk_valid); end
      start = 1'b0;
      if (c == 20) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    n_checks += 6;
    if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_mid_busy got %b expected 0", busy); end
    if (done !== 1'b0)     begin n_fail++; $display("FAIL rst_mid_done got %b expected 0", done); end
    if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rk_valid got %b expected 0", rk_valid); end
    if (rk_round !== 4'd0) begin n_fail++; $display("FAIL rst_mid_rk_round got %0d expected 0", rk_round); end
    if (rk_out !== '0)     begin n_fail++; $display("FAIL rst_mid_rk_out got %h expected 0", rk_out); end
    if (sub_in !== 32'h0)  begin n_fail++; $display("FAIL rst_mid_sub_in got %h expected 0", sub_in); end
    $display("test_rst_mid: reset applied, outputs cleared");
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n_checks++;
      if (rk_valid !== 1'b0 || busy !== 1'b0)
        begin n_fail++; $display("FAIL rst_mid_quiet cycle %0d got valid=%b busy=%b expected 0 0", c, rk_valid, busy); end
    end
    test_expansion(FIPS_KEY, 1'b0, 1'b0, 1'b1, FIPS_R1, FIPS_R10, "after_rst");
  endtask

  task automatic test_random();
    logic [127:0] k;
    for (int t = 0; t < 3; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      test_expansion(k, 1'b0, 1'b0, 1'b0, '0, '0, "random");
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_zero_key();
    test_back_to_back();
    test_ignored_start();
    @(negedge clk);
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_expand_ctrl.md
# aes_key_expand_ctrl

Word-serial AES-128 key-expansion sequencer. It drives one shared 32-bit SubWord S-box unit (`KeySubBytes`) through its `sub_in`/`sub_out` ports. From a 128-bit cipher key it generates round keys 0..10 in FIPS-197 order, at one expanded word per clock. It sits between the key register and the round pipeline, which consumes each round key on its `rk_valid` pulse.

## Interface
Parameters:
- none; AES-128 only, Nk=4, Nr=10.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin expansion; sampled only in IDLE.
- `key_in`  in  128  cipher key; `w0`=`key_in[127:96]` … `w3`=`key_in[31:0]`; captured on the accepted `start` edge.
- `busy`  out  1  high while expansion is in progress (EXPAND and DONE states).
- `done`  out  1  one-cycle pulse, coincident with the round-10 `rk_valid`.
- `rk_valid`  out  1  one-cycle pulse; `rk_out`/`rk_round` valid this cycle.
- `rk_round`  out  4  round index 0..10 of `rk_out`.
- `rk_out`  out  128  `{w0,w1,w2,w3}` window register.
- `sub_in`  out  32  to S-box: RotWord(`w3`) = `{w3[23:0], w3[31:24]}`, driven combinationally at all times.
- `sub_out`  in  32  from S-box, combinational; byte k of `sub_out` = S(byte k of `sub_in`).

## Operation
- State: window `w0..w3` (4×32), word index `j` (2 b), round counter `rnd` (4 b), `rcon` (8 b), FSM {IDLE, EXPAND, DONE}.
- **IDLE + `start`**
  - window ← `key_in`; `j`←0; `rnd`←0; `rcon`←8'h01.
  - `rk_valid`←1, `rk_round`←0.
  - → EXPAND.
- **EXPAND**, each cycle:
  - temp = (`j`==0) ? `sub_out` ^ {`rcon`, 24'h0} : `w3`.
  - new = `w0` ^ temp.
  - Shift the window: `w0`←`w1`, `w1`←`w2`, `w2`←`w3`, `w3`←new.
  - `j`←`j`+1, wrapping 3→0.
- **`j`==3 in EXPAND**
  - `rnd`←`rnd`+1.
  - `rk_valid`←1, `rk_round`←`rnd`+1.
  - `rcon`←xtime(`rcon`) = {`rcon`[6:0],1'b0} ^ (`rcon`[7] ? 8'h1B : 0). Sequence: 01,02,04,08,10,20,40,80,1B,36.
  - If `rnd`==9 → DONE; otherwise stay in EXPAND.
- **DONE**: `done`=1 for one cycle, then → IDLE unconditionally.
- `start` outside IDLE (EXPAND or DONE) is ignored; `key_in` is don't-care after capture.
- `rk_out` holds its last value between pulses; it is not cleared on `done`.
- Reset values:
  - window 0, `rk_out` 0.
  - `busy` 0, `done` 0, `rk_valid` 0.
  - `rk_round` 0, `j` 0, `rnd` 0, `rcon` 8'h01.
  - state IDLE.
- `rst` mid-expansion aborts immediately: all reset values are applied the next edge and no further `rk_valid` pulses occur.

## Timing
- `start` is sampled at edge 0.
- Round r appears with `rk_valid`=1 in cycle 1+4r: round 0 in cycle 1, round 10 in cycle 41.
- `done`=1 in cycle 41. `busy`=1 in cycles 1..41. Back in IDLE at cycle 42, where the earliest new `start` is sampled.
- Expansion takes 42 cycles start-to-start.
- `rk_valid` is never asserted on consecutive cycles: minimum gap 4 cycles.
- The S-box path is combinational, one word per cycle. Critical path: `w3` → S-box → XOR → `w3`.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, `start` pulse:
  - round 0 = key in cycle 1;
  - round 1 = a0fafe1788542cb123a339392a6c7605 in cycle 5;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with `done` in cycle 41;
  - exactly 11 `rk_valid` pulses, `rk_round` 0..10.
- All-zero key:
  - round 1 = 62636363626363636263636362636363;
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- `start` held high continuously with the FIPS key:
  - re-accepted only in cycle 42;
  - second run reproduces identical round keys, and `rcon` restarts at 01.
- `start` pulses plus a changed `key_in` in cycles 10 and 41 → ignored; round keys still match the first key.
- `rst` asserted in cycle 20:
  - cycle 21 shows all outputs at reset values;
  - no further `rk_valid`;
  - a new `start` yields the correct full sequence.
- Cycle-by-cycle check against a reference model: `rk_valid` spacing exactly 4, `busy` high exactly cycles 1..41, `sub_in` = RotWord(`w3`) in every cycle.
